// File: rtl/pc_fetch.sv
// pc_fetch: instruction fetch unit (imem request/ack in, branch redirect, stall, valid/ready instruction out)
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic [31:0]        imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               br_taken,
  input  logic [31:0]        br_target,
  input  logic               stall,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);
  typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} state_t;
  state_t state_q, state_d, resume;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, ipc_q, ipc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic valid_q, valid_d, req_q, req_d;
  always_comb begin
    resume = stall ? IDLE : REQ;
    state_d = state_q;
    pc_d = br_taken ? br_target : pc_q;
    instr_d = instr_q;
    ipc_d = ipc_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: state_d = resume;
      REQ: begin
        if (imem_ack && !br_taken) begin
          instr_d = imem_data;
          ipc_d = pc_q;
          pc_d = pc_q + 32'd1;
          valid_d = 1'b1;
          state_d = HOLD;
        end else if (imem_ack) state_d = resume;
        else if (br_taken) state_d = DRAIN;
      end
      DRAIN: if (imem_ack) state_d = resume;
      HOLD: if (br_taken || instr_ready) begin
        valid_d = 1'b0;
        state_d = resume;
      end
      default: state_d = IDLE;
    endcase
    addr_d = state_d == DRAIN ? addr_q : pc_d;
    req_d = state_d == REQ || state_d == DRAIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      addr_q <= RESET_PC;
      ipc_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
      ipc_q <= ipc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q <= req_d;
    end
  end
  assign imem_addr = addr_q;
  assign imem_req = req_q;
  assign instr = instr_q;
  assign instr_pc = ipc_q;
  assign instr_valid = valid_q;
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL provide parameter INSTR_W, default 16, instruction word width.
REQ-003 SHALL use one clock; reset synchronous, active-high.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 imem_addr  out  32  fetch address, equals internal pc.
REQ-007 imem_req  out  1  fetch request to instruction memory.
REQ-008 imem_ack  in  1  memory returns imem_data this cycle; completes request.
REQ-009 imem_data  in  INSTR_W  instruction word, valid only with imem_ack.
REQ-010 br_taken  in  1  single-cycle redirect pulse from execute.
REQ-011 br_target  in  32  redirect address from PC adder, sampled with br_taken.
REQ-012 stall  in  1  inhibits issue of new fetch requests.
REQ-013 instr  out  INSTR_W  fetched instruction.
REQ-014 instr_pc  out  32  address instr was fetched from.
REQ-015 instr_valid  out  1  instr/instr_pc valid.
REQ-016 instr_ready  in  1  consumer accepts; transfer when instr_valid && instr_ready.

Function
REQ-017 SHALL implement states IDLE, REQ, DRAIN, HOLD; all outputs registered.
REQ-018 IDLE: imem_req=0; next state REQ if stall=0, else IDLE.
REQ-019 REQ: imem_req=1, imem_addr=pc held constant until imem_ack.
REQ-020 REQ with imem_ack, br_taken=0: instr<=imem_data, instr_pc<=pc, pc<=pc+1, instr_valid<=1, -> HOLD.
REQ-021 pc increment SHALL be modulo 2^32 (32'hFFFF_FFFF+1 -> 0).
REQ-022 HOLD: imem_req=0; instr, instr_pc, instr_valid stable until handshake.
REQ-023 HOLD with handshake: instr_valid<=0; -> REQ if stall=0, else IDLE.
REQ-024 Fetch-to-valid latency SHALL be one cycle after the imem_ack cycle; zero-wait memory yields one instruction per 2 cycles min.
REQ-025 stall SHALL NOT abort an outstanding request; it only blocks leaving IDLE/HOLD/DRAIN toward REQ.
REQ-026 br_taken in any state SHALL load pc<=br_target on that edge; increment discarded.
REQ-027 br_taken in REQ without imem_ack: -> DRAIN; imem_req stays 1, imem_addr stays old pc until ack.
REQ-028 DRAIN: on imem_ack data discarded (instr_valid stays 0); -> REQ if stall=0, else IDLE.
REQ-029 br_taken in DRAIN: pc<=br_target, remain DRAIN.
REQ-030 br_taken with imem_ack in REQ: data discarded, pc<=br_target, -> REQ (IDLE if stall).
REQ-031 br_taken in HOLD: instr_valid<=0 (flush) next edge; -> REQ (IDLE if stall); concurrent handshake counts as delivered.
REQ-032 br_taken in IDLE: pc<=br_target; normal IDLE transition.
REQ-033 imem_ack in IDLE or HOLD SHALL be ignored.

Reset
REQ-034 rst=1 SHALL set pc=RESET_PC, state IDLE, imem_req=0, instr_valid=0, instr=0, instr_pc=0, overriding all inputs.
REQ-035 Reset mid-request SHALL drop the request; a later stray imem_ack is ignored.

Verification
REQ-036 Reset, stall=0, imem_ack=1 every REQ cycle, instr_ready=1, RESET_PC=0 -> instr_pc sequence 0,1,2,3; imem_req high alternate cycles.
REQ-037 Ack delayed 3 cycles at pc=5 -> imem_addr=5 and imem_req=1 held 4 cycles; instr_valid next cycle after ack.
REQ-038 instr_ready=0 for 4 cycles in HOLD -> instr/instr_pc unchanged, imem_req=0 throughout.
REQ-039 br_taken, br_target=32'h40 during outstanding fetch of 7 -> data for 7 never valid; next imem_addr=32'h40.
REQ-040 pc=32'hFFFF_FFFF fetch completes -> next imem_addr=0.
REQ-041 stall=1 during outstanding request -> request completes, instr delivered, no new imem_req until stall=0.
